// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath: byte width, header field
// positions and the reserved (never routed) address code.
package router_pkg;

    localparam int          DATA_W_DFLT       = 8;
    localparam logic [1:0]  ADDR_INVALID_DFLT = 2'b11;

    // Header byte layout: {payload_len[LEN_W-1:0], addr[1:0]}
    localparam int          ADDR_LSB = 0;
    localparam int          ADDR_W   = 2;
    localparam int          LEN_LSB  = 2;
    localparam int          LEN_W    = 6;

endpackage

// File: rtl/router_reg.sv
// Router datapath register stage: latches the header, steers payload/parity
// bytes to the FIFOs (with a one-byte hold while the FIFO is full) and checks parity.
module router_reg
    import router_pkg::*;
#(
    parameter int         DATA_W       = DATA_W_DFLT,
    parameter logic [1:0] ADDR_INVALID = ADDR_INVALID_DFLT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              laf_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err
);

    logic [DATA_W-1:0] r_header;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_int_parity;
    logic [DATA_W-1:0] r_pkt_parity;
    logic [DATA_W-1:0] r_dout;
    logic              r_parity_done;
    logic              r_low_pkt_valid;
    logic              r_err;

    logic w_hdr_ok;
    logic w_ld_byte;
    logic w_ld_parity;
    logic w_pd_set;

    function automatic logic parity_mismatch(input logic [DATA_W-1:0] calc,
                                             input logic [DATA_W-1:0] rcvd);
        return (calc != rcvd);
    endfunction

    // full_state is a pure hold cycle for this block; it only matters to the FSM.
    assign w_hdr_ok    = detect_add && pkt_valid &&
                         (data_in[ADDR_LSB +: ADDR_W] != ADDR_INVALID);
    assign w_ld_byte   = ld_state && pkt_valid;
    assign w_ld_parity = ld_state && !pkt_valid;
    assign w_pd_set    = (w_ld_parity && !fifo_full) || (laf_state && r_low_pkt_valid);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_header <= '0;
            r_hold   <= '0;
            r_dout   <= '0;
        end else begin
            if (w_hdr_ok)
                r_header <= data_in;
            if (ld_state && fifo_full)
                r_hold <= data_in;
            if (lfd_state)
                r_dout <= r_header;
            else if (ld_state && !fifo_full)
                r_dout <= data_in;
            else if (laf_state)
                r_dout <= r_hold;
        end
    end

    // Parity is accumulated at ld_state regardless of fifo_full, so a byte
    // parked in r_hold is counted on arrival and not again when replayed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_int_parity <= '0;
            r_pkt_parity <= '0;
        end else begin
            if (lfd_state)
                r_int_parity <= r_header;
            else if (w_ld_byte)
                r_int_parity <= r_int_parity ^ data_in;
            if (w_ld_parity)
                r_pkt_parity <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_low_pkt_valid <= 1'b0;
            r_parity_done   <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            if (w_ld_parity)
                r_low_pkt_valid <= 1'b1;
            else if (rst_int_reg)
                r_low_pkt_valid <= 1'b0;

            if (w_pd_set)
                r_parity_done <= 1'b1;
            else if (detect_add)
                r_parity_done <= 1'b0;

            // err persists through the next header decode so the FSM can see it.
            if (lfd_state)
                r_err <= 1'b0;
            else if (rst_int_reg)
                r_err <= parity_mismatch(r_int_parity, r_pkt_parity);
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router; sits directly downstream of router_fsm and upstream of the three output FIFOs.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg) and the input byte stream.
- Produces the registered byte to write into the selected FIFO (dout), plus packet status back to the FSM (parity_done, low_pkt_valid).
- Computes the running XOR parity and flags a parity mismatch (err).
- Packet format: header byte = {payload_len[7:2], addr[1:0]}, then payload_len payload bytes, then one parity byte (XOR of header and all payload bytes). pkt_valid is high for header and payload, low for the parity byte.

Parameters:
- DATA_W, 8, byte width of data_in and dout.
- ADDR_INVALID, 2'b11, header address value that is never latched.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  source marks header/payload bytes valid.
- data_in  in  DATA_W  input byte stream.
- fifo_full  in  1  selected output FIFO is full.
- detect_add  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR.
- dout  out  DATA_W  registered byte presented to the FIFOs.
- parity_done  out  1  parity byte has been captured for the current packet.
- low_pkt_valid  out  1  pkt_valid has fallen during the current packet.
- err  out  1  computed parity differs from the received parity byte.

Behaviour:
- Interface: one clock (clock); reset resetn is asynchronous and active-low. It clears all registers on assertion, independent of clock.
- Reset values: dout=0, parity_done=0, low_pkt_valid=0, err=0. Internal header_reg, hold_reg, int_parity and pkt_parity are all 0.
- Timing: all outputs are registered; an update takes effect one cycle after the qualifying inputs.
- Header latch: detect_add && pkt_valid && data_in[1:0]!=ADDR_INVALID -> header_reg<=data_in. Otherwise header_reg holds.
- lfd_state: dout<=header_reg; int_parity<=header_reg; err<=0.
- ld_state && !fifo_full: dout<=data_in. This includes the parity byte, which is written by the FSM in LOAD_PARITY.
- ld_state && fifo_full: hold_reg<=data_in and dout holds.
- laf_state: dout<=hold_reg.
- full_state, rst_int_reg, detect_add (and any other state): dout holds.
- Parity accumulation: ld_state && pkt_valid -> int_parity<=int_parity^data_in. This counts the byte whether it went to dout or hold_reg, so each payload byte is counted exactly once.
- Parity capture: ld_state && !pkt_valid -> pkt_parity<=data_in.
- low_pkt_valid: set on ld_state && !pkt_valid; cleared on rst_int_reg. Set has priority if both occur.
- parity_done: set on (ld_state && !pkt_valid && !fifo_full) or (laf_state && low_pkt_valid); cleared on detect_add. Set has priority.
- err: on rst_int_reg, err<=(int_parity!=pkt_parity). It is held through DECODE_ADDRESS and cleared at the next lfd_state, so a mismatch is visible for at least 2 cycles.
- Full during the parity byte: the byte goes to hold_reg and pkt_parity; parity_done stays 0 until the LAF cycle, where low_pkt_valid=1 sets it.
- Zero-length packet: header then immediately the parity byte. int_parity=header; this path must work.
- Header with addr=ADDR_INVALID: header_reg is not updated and no other register changes (the FSM stays in DECODE).
- Reset mid-packet: everything clears asynchronously; the next packet starts clean.
- FSM soft resets are not visible to this block. Stale status is cleared by detect_add/lfd_state on the next packet.

Decomposition:
- Shared package router_pkg holds the DATA_W default, ADDR_INVALID, and the header field positions (ADDR_LSB=0, LEN_LSB=2, LEN_W=6).
- No sub-module: a single flat module of about 150 lines. The parity XOR accumulator is inline.

Test Plan:
- Reset: assert resetn=0 mid-packet with dout=8'hA5 -> all outputs 0 immediately, without waiting for a clock edge.
- Good packet: header 8'h0D (len 3, addr 1), payload 11,22,33, parity 8'h0D^11^22^33 -> dout sequence 0D,11,22,33,parity on consecutive cycles. parity_done=1 the cycle after the parity byte; err=0 after rst_int_reg.
- Corrupt parity: same packet with parity byte XOR 8'h01 -> err=1 the cycle after rst_int_reg, held until the next lfd_state.
- Full mid-payload: fifo_full=1 while ld_state with data_in=8'h22 -> dout holds 8'h11. After full_state and then laf_state, dout=8'h22. Final parity matches and err=0.
- Full on parity byte: fifo_full=1 when pkt_valid falls -> low_pkt_valid=1, parity_done stays 0; parity_done=1 after the laf_state cycle; low_pkt_valid clears after rst_int_reg.
- Zero-length and invalid address: header 8'h02 then parity 8'h02 -> err=0. Header 8'h07 (addr 3) -> header_reg unchanged.
